// File: rtl/adc_capture.sv
// ADC capture block: generates the ADC sample clock, decimates the sample stream,
// waits for an armed trigger and records a fixed-length block into a readable RAM.
module adc_capture #(
    parameter int DW = 14,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] AD_DATA,
    output logic          AD_CLK,
    input  logic          arm,
    input  logic [1:0]    trig_mode,
    input  logic [DW-1:0] trig_level,
    input  logic [7:0]    decim,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic          ph_r;
    logic [DW-1:0] cur_r;
    logic [DW-1:0] prev_r;
    logic          prev_valid_r, prev_valid_nxt_s;
    logic [7:0]    dcnt_r;
    logic [7:0]    dlim_r;
    logic          smp_stb_r;
    logic [AW-1:0] waddr_r, waddr_nxt_s;
    logic          we_s;
    logic          trig_s;
    logic          busy_r, done_r;
    logic [DW-1:0] rd_data_r;
    logic [DW-1:0] mem_r [0:DEPTH-1];

    logic adc_stb_s;
    logic arm_acc_s;

    // The strobe cycle is the one in which the phase bit falls 1->0.
    assign adc_stb_s = ph_r;
    assign arm_acc_s = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    assign AD_CLK  = ph_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_data = rd_data_r;

    // Sample clock phase, ADC sampling, decimation counter and previous-sample history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_r      <= 1'b0;
            cur_r     <= {DW{1'b0}};
            prev_r    <= {DW{1'b0}};
            dcnt_r    <= 8'd0;
            dlim_r    <= 8'd0;
            smp_stb_r <= 1'b0;
        end else begin
            ph_r      <= ~ph_r;
            smp_stb_r <= adc_stb_s && (dcnt_r == 8'd0);
            if (adc_stb_s) begin
                cur_r <= AD_DATA;
            end
            if (smp_stb_r) begin
                prev_r <= cur_r;
            end
            // The decimation limit is only reloaded at a wrap so a change never truncates a period.
            if (arm_acc_s) begin
                dcnt_r <= 8'd0;
                dlim_r <= decim;
            end else if (adc_stb_s) begin
                if (dcnt_r == dlim_r) begin
                    dcnt_r <= 8'd0;
                    dlim_r <= decim;
                end else begin
                    dcnt_r <= dcnt_r + 8'd1;
                end
            end
        end
    end

    // Trigger condition evaluated on the current kept sample against the previous one.
    always_comb begin
        trig_s = 1'b1;
        case (trig_mode)
            2'b01:   trig_s = prev_valid_r && (prev_r < trig_level) && (cur_r >= trig_level);
            2'b10:   trig_s = prev_valid_r && (prev_r >= trig_level) && (cur_r < trig_level);
            default: trig_s = 1'b1;
        endcase
    end

    // Capture FSM next-state, write enable and write-address logic.
    always_comb begin
        state_nxt_s      = state_r;
        waddr_nxt_s      = waddr_r;
        prev_valid_nxt_s = prev_valid_r;
        we_s             = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_nxt_s      = ST_ARMED;
                    waddr_nxt_s      = ADDR_ZERO;
                    prev_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ARMED: begin
                if (smp_stb_r) begin
                    prev_valid_nxt_s = 1'b1;
                    if (trig_s) begin
                        we_s        = 1'b1;
                        waddr_nxt_s = ADDR_ONE;
                        state_nxt_s = ST_CAPTURE;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (smp_stb_r) begin
                    we_s = 1'b1;
                    if (waddr_r == ADDR_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        waddr_nxt_s = waddr_r + ADDR_ONE;
                    end
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            waddr_r      <= ADDR_ZERO;
            prev_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            waddr_r      <= waddr_nxt_s;
            prev_valid_r <= prev_valid_nxt_s;
            busy_r       <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CAPTURE);
            done_r       <= (state_nxt_s == ST_DONE);
        end
    end

    // Record buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem_r[waddr_r] <= cur_r;
        end
    end

    // Record buffer read port, one cycle latency, old data on a same-address write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DW{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Randomized self-checking bench for adc_capture: logs every ADC strobe and derives
// the expected record from decimation and trigger rules applied to that log.
module tb_adc_capture;

    localparam int DW    = 14;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int LVL   = 'h2000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] AD_DATA;
    logic          AD_CLK;
    logic          arm;
    logic [1:0]    trig_mode;
    logic [DW-1:0] trig_level;
    logic [7:0]    decim;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    bit            ph_m     = 1'b0;
    int            strobe_n = 0;
    logic [DW-1:0] log_q[$];
    int            gen_mode  = 0;
    int            ramp_base = 0;
    int            tri_step  = 1;
    int            const_val = 'h1000;
    logic [DW-1:0] exp_mem [DEPTH];

    adc_capture #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .AD_DATA    (AD_DATA),
        .AD_CLK     (AD_CLK),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .decim      (decim),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] gen_sample(input int n);
        int p;
        case (gen_mode)
            0: return DW'((ramp_base + n) & 'h3FFF);
            1: begin
                p = (n * tri_step) % 32766;
                return DW'((p <= 16383) ? p : (32766 - p));
            end
            default: return DW'(const_val);
        endcase
    endfunction

    // Strobe log: the ADC is sampled on every second clock after reset (phase 1 -> 0).
    always @(posedge clk) begin
        if (rst) ph_m = 1'b0;
        else begin
            if (ph_m) begin
                log_q.push_back(AD_DATA);
                strobe_n++;
            end
            ph_m = !ph_m;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            AD_DATA = gen_sample(strobe_n);
        end
    end

    // Pulse arm on a non-strobe edge; an accepted arm starts a fresh strobe log.
    task automatic do_arm(input bit accept, input bit set_const, input int cval);
        @(negedge clk);
        if (ph_m) @(negedge clk);
        if (accept) log_q.delete();
        if (set_const) const_val = cval;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic build_expected(input int mode, input int lvl, input int d, output bit ok);
        logic [DW-1:0] kept[$];
        int j;
        for (int i = 0; i < log_q.size(); i += d + 1) kept.push_back(log_q[i]);
        j = -1;
        if (mode == 1 || mode == 2) begin
            for (int k = 1; k < kept.size(); k++) begin
                if ((mode == 1 && int'(kept[k-1]) < lvl && int'(kept[k]) >= lvl) ||
                    (mode == 2 && int'(kept[k-1]) >= lvl && int'(kept[k]) < lvl)) begin
                    j = k;
                    break;
                end
            end
        end else begin
            j = 0;
        end
        ok = (j >= 0) && (j + DEPTH <= kept.size());
        if (ok) for (int i = 0; i < DEPTH; i++) exp_mem[i] = kept[j + i];
    endtask

    task automatic run_capture(input string tag, input int mode, input int lvl, input int d,
                               input bit check_time);
        int cyc;
        bit ok;
        trig_mode  = 2'(mode);
        trig_level = DW'(lvl);
        decim      = 8'(d);
        do_arm(1'b1, 1'b0, 0);
        check_eq({tag, ".busy_armed"}, int'(busy), 1);
        check_eq({tag, ".done_armed"}, int'(done), 0);
        cyc = 0;
        while (!done && cyc < 2 * (d + 1) * DEPTH + 40000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, ".done"}, int'(done), 1);
        check_eq({tag, ".busy_done"}, int'(busy), 0);
        if (check_time) check_eq({tag, ".cycles"}, cyc, 2 + 2 * (d + 1) * (DEPTH - 1));
        build_expected(mode, lvl, d, ok);
        check_eq({tag, ".model_trigger_found"}, int'(ok), 1);
        if (ok) begin
            for (int a = 0; a < DEPTH; a++) begin
                rd_addr = AW'(a);
                @(negedge clk);
                check_eq($sformatf("%s.rd[%0d]", tag, a), int'(rd_data), int'(exp_mem[a]));
            end
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; arm = 1'b0; trig_mode = 2'b00; trig_level = '0; decim = 8'd0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.busy", int'(busy), 0);
        check_eq("rst.done", int'(done), 0);
        check_eq("rst.ad_clk", int'(AD_CLK), 0);
        check_eq("rst.rd_data", int'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("adclk.hi", int'(AD_CLK), 1);
        @(negedge clk);
        check_eq("adclk.lo", int'(AD_CLK), 0);

        // Immediate capture of a ramp, mode 00 or 11.
        gen_mode = 0; ramp_base = 'h0100 - strobe_n;
        run_capture("imm", ($urandom_range(0, 1) != 0) ? 3 : 0, 0, 0, 1'b1);

        // Rising and falling edge triggers on a triangle.
        gen_mode = 1; tri_step = $urandom_range(40, 120);
        run_capture("rise", 1, LVL, $urandom_range(0, 1), 1'b0);
        tri_step = $urandom_range(40, 120);
        run_capture("fall", 2, LVL, $urandom_range(0, 2), 1'b0);

        // Decimated ramp: one kept sample every 8 clocks.
        gen_mode = 0; ramp_base = $urandom_range(0, 'h3FFF);
        run_capture("decim", 0, 0, 3, 1'b1);

        // Falling mode where the first post-arm sample is below level after a high history.
        gen_mode = 2; const_val = 'h3000; trig_mode = 2'b10; trig_level = DW'(LVL); decim = 8'd0;
        repeat (20) @(negedge clk);
        do_arm(1'b1, 1'b1, 'h1000);
        repeat (2 * DEPTH + 100) @(negedge clk);
        check_eq("notrig.fall_busy", int'(busy), 1);
        check_eq("notrig.fall_done", int'(done), 0);
        trig_mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            do_arm(1'b0, 1'b0, 0);
            repeat ($urandom_range(5, 40)) @(negedge clk);
        end
        check_eq("notrig.rise_busy", int'(busy), 1);
        check_eq("notrig.rise_done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("notrig.rst_busy", int'(busy), 0);
        gen_mode = 0; ramp_base = $urandom_range(0, 'h3FFF);
        run_capture("rearm", 0, 0, 0, 1'b1);

        // Reset in the middle of a capture, then a clean re-arm.
        trig_mode = 2'b00; decim = 8'd0;
        do_arm(1'b1, 1'b0, 0);
        cyc = 0;
        while (cyc < DEPTH) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mid.busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid.busy", int'(busy), 0);
        check_eq("mid.done", int'(done), 0);
        check_eq("mid.ad_clk", int'(AD_CLK), 0);
        check_eq("mid.rd_data", int'(rd_data), 0);
        rst = 1'b0;
        ramp_base = 'h0100 - strobe_n;
        run_capture("mid_rearm", 0, 0, $urandom_range(0, 1), 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
